// File: rtl/coin_payment_unit.sv
// Payment stage of the coffee machine: collects coins against the latched drink
// cost, holds paid until serving finishes, then returns change one unit per clock.
module coin_payment_unit #(
  parameter int unsigned COST_W    = 3,
  parameter int unsigned AMT_W     = 4,
  parameter int unsigned MAX_AMT   = 15,
  parameter int unsigned COIN0_VAL = 1,
  parameter int unsigned COIN1_VAL = 2,
  parameter int unsigned COIN2_VAL = 5,
  parameter int unsigned COIN3_VAL = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_valid,
  input  logic [COST_W-1:0] cost,
  input  logic              coin_valid,
  input  logic [1:0]        coin_type,
  input  logic              cancel,
  input  logic              serve_done,
  output logic [AMT_W-1:0]  amount,
  output logic              paid,
  output logic              change_pulse,
  output logic              coin_reject,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, PAID, REFUND} state_t;

  state_t            state;
  logic [COST_W-1:0] cost_reg;
  logic [AMT_W:0]    coin_val;
  logic [AMT_W:0]    sum;
  logic [AMT_W-1:0]  cost_ext;
  logic [AMT_W-1:0]  diff;

  always_comb begin
    coin_val = '0;
    case (coin_type)
      2'd0:    coin_val = (AMT_W+1)'(COIN0_VAL);
      2'd1:    coin_val = (AMT_W+1)'(COIN1_VAL);
      2'd2:    coin_val = (AMT_W+1)'(COIN2_VAL);
      default: coin_val = (AMT_W+1)'(COIN3_VAL);
    endcase
    // One extra bit so an overflowing coin is detectable instead of wrapping
    sum      = {1'b0, amount} + coin_val;
    cost_ext = AMT_W'(cost_reg);
    diff     = amount - cost_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      amount       <= '0;
      cost_reg     <= '0;
      paid         <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      case (state)
        IDLE: begin
          coin_reject <= coin_valid;
          if (sel_valid && cost != '0) begin
            cost_reg <= cost;
            state    <= COLLECT;
            busy     <= 1'b1;
          end
        end
        COLLECT: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            if (amount == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= REFUND;
            end
          end else if (amount >= cost_ext) begin
            // Payment is judged on the registered amount, one cycle after the coin lands
            state       <= PAID;
            paid        <= 1'b1;
            coin_reject <= coin_valid;
          end else if (coin_valid) begin
            if (sum > (AMT_W+1)'(MAX_AMT)) coin_reject <= 1'b1;
            else                           amount      <= sum[AMT_W-1:0];
          end
        end
        PAID: begin
          coin_reject <= coin_valid;
          if (serve_done) begin
            amount <= diff;
            paid   <= 1'b0;
            if (diff != '0) begin
              state <= REFUND;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          coin_reject <= coin_valid;
          if (amount != '0) begin
            change_pulse <= 1'b1;
            amount       <= amount - 1'b1;
          end
          if (amount <= AMT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_payment_unit.sv
// Scoreboard bench for coin_payment_unit: each distinct output tuple
// {amount,paid,change_pulse,coin_reject,busy} is queued ahead and checked in order.
module tb_coin_payment_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_valid;
  logic [2:0] cost;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic       serve_done;
  logic [3:0] amount;
  logic       paid;
  logic       change_pulse;
  logic       coin_reject;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev;
  logic       mon_en = 1'b0;

  coin_payment_unit #(
    .COST_W(3), .AMT_W(4), .MAX_AMT(15),
    .COIN0_VAL(1), .COIN1_VAL(2), .COIN2_VAL(5), .COIN3_VAL(10)
  ) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .cost(cost),
    .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
    .serve_done(serve_done), .amount(amount), .paid(paid),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got amt=%0d paid=%b chg=%b rej=%b busy=%b, want amt=%0d paid=%b chg=%b rej=%b busy=%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               req[7:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  function automatic logic [7:0] outs();
    return {amount, paid, change_pulse, coin_reject, busy};
  endfunction

  task automatic e(input int amt, input bit p, input bit c, input bit r, input bit b);
    exp_q.push_back({4'(amt), p, c, r, b});
  endtask

  // Monitor: every change of the output tuple is one DUT response to score
  always @(negedge clk) begin
    if (mon_en && outs() !== prev) begin
      if (exp_q.size() == 0) check("unexpected_output", outs(), prev);
      else                   check("scoreboard", outs(), exp_q.pop_front());
      prev = outs();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [2:0] c);
    @(posedge clk); #1 sel_valid = 1'b1; cost = c;
    @(posedge clk); #1 sel_valid = 1'b0; cost = '0;
  endtask

  task automatic coin(input logic [1:0] t, input bit with_cancel);
    @(posedge clk); #1 coin_valid = 1'b1; coin_type = t; cancel = with_cancel;
    @(posedge clk); #1 coin_valid = 1'b0; coin_type = '0; cancel = 1'b0;
  endtask

  task automatic do_cancel();
    @(posedge clk); #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
  endtask

  task automatic serve();
    @(posedge clk); #1 serve_done = 1'b1;
    @(posedge clk); #1 serve_done = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected responses still pending, want 0", name, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; sel_valid = 1'b0; cost = '0; coin_valid = 1'b0; coin_type = '0;
    cancel = 1'b0; serve_done = 1'b0;
    idle(3);
    check("reset_state", outs(), 8'h00);
    rst = 1'b0;
    idle(2);
    check("idle_after_reset", outs(), 8'h00);
    prev = outs();
    mon_en = 1'b1;

    // T1 exact pay, also checks the two-cycle paid latency
    e(0,0,0,0,1); sel(3'd3);
    e(2,0,0,0,1); coin(2'd1, 0);
    e(3,0,0,0,1); e(3,1,0,0,1); coin(2'd0, 0);
    check("paid_lat1", {7'd0, paid}, 8'h00);
    @(posedge clk); #1;
    check("paid_lat2", {7'd0, paid}, 8'h01);
    idle(2);
    e(0,0,0,0,0); serve();
    drain("t1_exact");

    // T2 overpay -> two change pulses
    e(0,0,0,0,1); sel(3'd3);
    e(5,0,0,0,1); e(5,1,0,0,1); coin(2'd2, 0);
    idle(3);
    e(2,0,0,0,1); e(1,0,1,0,1); e(0,0,1,0,0); e(0,0,0,0,0); serve();
    drain("t2_overpay");

    // T3 cancel refunds what was inserted
    e(0,0,0,0,1); sel(3'd4);
    e(2,0,0,0,1); coin(2'd1, 0);
    idle(2);
    e(1,0,1,0,1); e(0,0,1,0,0); e(0,0,0,0,0); do_cancel();
    drain("t3_cancel");

    // T4 overflow rejection, then cancel to unwind
    e(0,0,0,0,1); sel(3'd7);
    e(5,0,0,0,1); coin(2'd2, 0);
    e(6,0,0,0,1); coin(2'd0, 0);
    e(6,0,0,1,1); e(6,0,0,0,1); coin(2'd3, 0);
    idle(2);
    e(5,0,1,0,1); e(4,0,1,0,1); e(3,0,1,0,1); e(2,0,1,0,1); e(1,0,1,0,1);
    e(0,0,1,0,0); e(0,0,0,0,0); do_cancel();
    drain("t4_overflow");

    // T5 coin in IDLE, then cancel with a coin in the same cycle
    e(0,0,0,1,0); e(0,0,0,0,0); coin(2'd3, 0);
    drain("t5_idle_coin");
    e(0,0,0,0,1); sel(3'd5);
    e(2,0,0,0,1); coin(2'd1, 0);
    e(2,0,0,1,1); e(1,0,1,0,1); e(0,0,1,0,0); e(0,0,0,0,0); coin(2'd3, 1);
    drain("t5_cancel_coin");

    // sel with cost 0 is ignored
    sel(3'd0);
    idle(2);
    check("zero_cost_ignored", outs(), 8'h00);

    // T6 reset during REFUND with amount 3
    e(0,0,0,0,1); sel(3'd7);
    e(5,0,0,0,1); coin(2'd2, 0);
    e(10,0,0,0,1); e(10,1,0,0,1); coin(2'd2, 0);
    idle(2);
    e(3,0,0,0,1); e(0,0,0,0,0); serve();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    check("after_reset_refund", outs(), 8'h00);
    drain("t6_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want finish before it");
    $fatal(1);
  end

endmodule
